ex_madd_seq: RTL and testbench

- EX-stage multi-cycle multiply-accumulate sequencer for madd, maddu, msub and msubu.
- It sits opposite the EX/MEM register. It owns the multi-cycle iteration state that the EX/MEM register does not hold.
- It raises a stall request to ctrl while the operation runs. It delivers the final HI/LO pair with a HI/LO write enable toward MEM.

---
 rtl/ex_madd_seq_if.sv | 31 +++
 rtl/ex_madd_seq.sv | 108 ++++++++++
 tb/tb_ex_madd_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_madd_seq_if.sv
// Bus between the EX stage and the multi-cycle multiply-accumulate sequencer.
// Handshake: start_i is accepted only in a cycle where the sequencer is idle and annul_i is
// low; ready_o/whilo_o then stay high with a stable result until a cycle with hold_i low.
interface ex_madd_seq_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] opa_i;
  logic [DATA_W-1:0] opb_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              annul_i;
  logic              hold_i;
  logic              stallreq_o;
  logic              ready_o;
  logic              whilo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        dbg_state;

  modport master (
    output start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i, hold_i,
    input  stallreq_o, ready_o, whilo_o, hi_o, lo_o, dbg_state
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i, hold_i,
    output stallreq_o, ready_o, whilo_o, hi_o, lo_o, dbg_state
  );
endinterface

// File: rtl/ex_madd_seq.sv
// EX-stage sequencer for madd/maddu/msub/msubu: multiply in one cycle, accumulate in the
// next, then present the HI/LO pair with a write enable until downstream releases it.
module ex_madd_seq #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_madd_seq_if.slave bus
);
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] opa_q, opb_q, hi_q, lo_q;
  logic [W2-1:0]     prod_q, acc_q;

  logic              accept;
  logic              sext;
  logic [W2-1:0]     ext_a, ext_b, base;

  assign accept = (state_q == ST_IDLE) && bus.start_i && !bus.annul_i;

  // op[0]=0 selects the signed variants; unsigned ones zero-extend.
  assign sext  = ~op_q[0];
  assign ext_a = {{DATA_W{sext & opa_q[DATA_W-1]}}, opa_q};
  assign ext_b = {{DATA_W{sext & opb_q[DATA_W-1]}}, opb_q};
  assign base  = {hi_q, lo_q};

  assign bus.dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.op_i;
        opa_q <= bus.opa_i;
        opb_q <= bus.opb_i;
        hi_q  <= bus.hi_i;
        lo_q  <= bus.lo_i;
      end
      if (state_q == ST_MUL) begin
        prod_q <= ext_a * ext_b;
      end
      // Wraps modulo 2^W2; madd-class ops never trap on overflow.
      if (state_q == ST_ACC) begin
        acc_q <= op_q[1] ? (base - prod_q) : (base + prod_q);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.stallreq_o = 1'b0;
    bus.ready_o    = 1'b0;
    bus.whilo_o    = 1'b0;
    bus.hi_o       = '0;
    bus.lo_o       = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d        = ST_MUL;
          // Gated by reset so every output is low while rst is asserted.
          bus.stallreq_o = rst;
        end
      end
      ST_MUL: begin
        bus.stallreq_o = 1'b1;
        state_d        = bus.annul_i ? ST_IDLE : ST_ACC;
      end
      ST_ACC: begin
        bus.stallreq_o = 1'b1;
        state_d        = bus.annul_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        bus.ready_o = 1'b1;
        bus.whilo_o = 1'b1;
        bus.hi_o    = acc_q[W2-1:DATA_W];
        bus.lo_o    = acc_q[DATA_W-1:0];
        if (bus.annul_i || !bus.hold_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ex_madd_seq.sv
// Testbench for ex_madd_seq: directed cases with literal results plus random traffic checked
// every cycle against an arithmetic reference model and an expected-result queue.
module tb_ex_madd_seq;
  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 0;

  ex_madd_seq_if #(.DATA_W(DATA_W)) bus ();

  ex_madd_seq #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full-width product of the extended operands, then add/sub on {hi,lo}.
  function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] hi,
                                       input logic [31:0] lo);
    longint    sa, sb;
    logic [63:0] p;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    return op[1] ? ({hi, lo} - p) : ({hi, lo} + p);
  endfunction

  // ---------------- reference model ----------------
  // m_age: 0 = no operation, 1..2 = cycles spent computing, 3 = result on the bus.
  int          m_age = 0;
  logic [63:0] m_res = '0;
  logic [63:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst || bus.annul_i) begin
      if ((m_age == 1 || m_age == 2) && exp_q.size() > 0) void'(exp_q.pop_back());
      m_age = 0;
    end else if (m_age == 0) begin
      if (bus.start_i) begin
        m_res = calc(bus.op_i, bus.opa_i, bus.opb_i, bus.hi_i, bus.lo_i);
        exp_q.push_back(m_res);
        m_age = 1;
      end
    end else if (m_age < 3) begin
      m_age = m_age + 1;
    end else if (!bus.hold_i) begin
      m_age = 0;
    end
  end

  // ---------------- compare process ----------------
  logic        prev_whilo = 1'b0;
  logic        e_stall, e_ready;
  logic [63:0] e_res, sb_res;

  always @(negedge clk) begin
    if (cmp_on) begin
      e_ready = rst && (m_age == 3);
      e_stall = rst && ((m_age == 0) ? (bus.start_i && !bus.annul_i) : (m_age != 3));
      e_res   = e_ready ? m_res : 64'd0;
      check("cycle_outputs",
            {5'd0, bus.stallreq_o, bus.ready_o, bus.whilo_o, bus.hi_o, bus.lo_o},
            {5'd0, e_stall, e_ready, e_ready, e_res});
      if (bus.whilo_o && !prev_whilo) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_unexpected_write", 72'd1, 72'd0);
        end else begin
          sb_res = exp_q.pop_front();
          check("scoreboard_result", {8'd0, bus.hi_o, bus.lo_o}, {8'd0, sb_res});
        end
      end
      prev_whilo = bus.whilo_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start_i = 1'b0;
    bus.op_i    = 2'd0;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.hi_i    = '0;
    bus.lo_i    = '0;
    bus.annul_i = 1'b0;
    bus.hold_i  = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Issue one op, check stall length, latency, literal result and hold behaviour.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int hold_cycles, input logic [63:0] exp_res);
    int n_stall = 0;
    int n_ready = 0;
    bit got = 0;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.hi_i    = hi;
    bus.lo_i    = lo;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        got = 1;
        break;
      end
      if (bus.stallreq_o) n_stall++;
      @(posedge clk); #1;
      // Inputs after the start cycle must be ignored.
      bus.start_i = 1'b0;
      bus.opa_i   = $urandom();
      bus.opb_i   = $urandom();
      bus.hi_i    = $urandom();
      bus.lo_i    = $urandom();
    end
    if (!got) begin
      check({name, "_timeout"}, 72'd0, 72'd1);
      return;
    end
    check({name, "_stall_cycles"}, 72'(n_stall), 72'd3);
    check({name, "_result"}, {8'd0, bus.hi_o, bus.lo_o}, {8'd0, exp_res});
    n_ready = 1;
    bus.hold_i = (hold_cycles > 0);
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o && bus.whilo_o && !bus.stallreq_o && {bus.hi_o, bus.lo_o} == exp_res)
        n_ready++;
    end
    bus.hold_i = 1'b0;
    check({name, "_ready_cycles"}, 72'(n_ready), 72'(hold_cycles + 1));
    @(posedge clk);
    @(negedge clk);
    check({name, "_back_to_idle"}, {70'd0, bus.ready_o, bus.whilo_o}, 72'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 cmp_on = 1;
    @(negedge clk);
    check("reset_outputs",
          {5'd0, bus.stallreq_o, bus.ready_o, bus.whilo_o, bus.hi_o, bus.lo_o}, 72'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Pin the reference model against hand-computed values.
    check("model_maddu", {8'd0, calc(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1)},
          {8'd0, 64'h0000_0001_FFFF_FFFF});
    check("model_msub", {8'd0, calc(2'b10, 32'd3, 32'd4, 32'd0, 32'd0)},
          {8'd0, 64'hFFFF_FFFF_FFFF_FFF4});

    run_op("maddu", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 0, 64'h0000_0001_FFFF_FFFF);
    run_op("madd",  2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd5, 0, 64'h0000_0000_0000_0003);
    run_op("msub",  2'b10, 32'd3, 32'd4, 32'd0, 32'd0, 0, 64'hFFFF_FFFF_FFFF_FFF4);
    run_op("msubu", 2'b11, 32'd1, 32'd1, 32'd0, 32'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("hold4", 2'b00, 32'd7, 32'd6, 32'd0, 32'd0, 4, 64'h0000_0000_0000_002A);

    // Annul while multiplying: the operation vanishes and a later op completes normally.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.opa_i   = 32'd100;
    bus.opb_i   = 32'd100;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    @(negedge clk);
    check("annul_mul_no_write", {71'd0, bus.whilo_o}, 72'd0);
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    check("annul_idle", {70'd0, bus.stallreq_o, bus.whilo_o}, 72'd0);
    run_op("after_annul", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 0, 64'h0000_0000_0000_0004);

    // Asynchronous reset in the accumulate cycle.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.op_i    = 2'b01;
    bus.opa_i   = 32'd9;
    bus.opb_i   = 32'd9;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {5'd0, bus.stallreq_o, bus.ready_o, bus.whilo_o, bus.hi_o, bus.lo_o}, 72'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_no_write", {71'd0, bus.whilo_o}, 72'd0);
    end

    // Random traffic: starts, annuls and holds in any state, checked every cycle.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      bus.start_i = ($urandom_range(0, 2) == 0);
      bus.op_i    = 2'($urandom_range(0, 3));
      bus.opa_i   = rand_word();
      bus.opb_i   = rand_word();
      bus.hi_i    = rand_word();
      bus.lo_i    = rand_word();
      bus.annul_i = ($urandom_range(0, 15) == 0);
      bus.hold_i  = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < 6; i++) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 72'(exp_q.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
